// File: rtl/fetch_pkg.sv
// Shared widths and the FIFO entry layout for the instruction fetch front end.
package fetch_pkg;
  localparam int BYTES_PER_INST = 4;
  localparam int WORD_W         = 32;
  localparam int PC_W           = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [WORD_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO of {pc, inst} entries with a synchronous flush.
// Head is a direct read of the oldest slot; push when full and pop when empty are ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [PC_W-1:0]            push_pc_i,
  input  logic [WORD_W-1:0]          push_inst_i,
  input  logic                       pop_i,
  output logic [PC_W-1:0]            head_pc_o,
  output logic [WORD_W-1:0]          head_inst_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Slots are cleared on reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push && !flush_i) mem_q[wr_q] <= '{pc: push_pc_i, inst: push_inst_i};
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head_pc_o   = mem_q[rd_q].pc;
  assign head_inst_o = mem_q[rd_q].inst;
  assign count_o     = count_q;
endmodule

// File: rtl/inst_fetch_buffer.sv
// Byte-serial big-endian fetch: assembles 32-bit words from a byte-wide memory into a FWFT queue.
// Redirect flushes queue and partial word and restarts at the new word-aligned PC.
module inst_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int IMEM_AW = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic [7:0]                 imem_rdata,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [WORD_W-1:0]          inst,
  output logic [PC_W-1:0]            inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);

  logic [PC_W-1:0] fpc_q, fpc_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [23:0]     asm_q, asm_d;
  logic            fetch_en, last_byte, push, pop;

  // Fetch is gated on the registered count only, so a full queue never stalls mid-word.
  assign fetch_en  = (count != CW'(DEPTH));
  assign last_byte = (byte_idx_q == 2'(BYTES_PER_INST - 1));
  assign push      = fetch_en && last_byte && !redirect;
  assign pop       = inst_valid && inst_ready && !redirect;
  assign imem_addr = fpc_q[IMEM_AW-1:0] + IMEM_AW'(byte_idx_q);

  always_comb begin
    fpc_d      = fpc_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    if (redirect) begin
      fpc_d      = redirect_pc & ~32'h3;
      byte_idx_d = '0;
      asm_d      = '0;
    end else if (fetch_en) begin
      if (last_byte) begin
        fpc_d      = fpc_q + PC_W'(BYTES_PER_INST);
        byte_idx_d = '0;
      end else begin
        asm_d      = {asm_q[15:0], imem_rdata};
        byte_idx_d = byte_idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q      <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
    end else begin
      fpc_q      <= fpc_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (redirect),
    .push_i      (push),
    .push_pc_i   (fpc_q),
    .push_inst_i ({asm_q, imem_rdata}),
    .pop_i       (pop),
    .head_pc_o   (inst_pc),
    .head_inst_o (inst),
    .count_o     (count)
  );

  assign inst_valid = (count != '0);
endmodule
